// File: rtl/user_proj_timer_mc.sv
// NCH independent up-counting timers sharing one prescaler, with Wishbone
// register access, per-channel PWM outputs and one combined level interrupt.
module user_proj_timer_mc #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int PRE_W = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           wbs_stb_i,
  input  logic           wbs_cyc_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  output logic [NCH-1:0] pwm_o,
  output logic [NCH-1:0] pwm_oeb_o,
  output logic           irq_o
);

  localparam logic [5:0] ADR_STATUS   = 6'h3C;
  localparam logic [5:0] ADR_PRESCALE = 6'h3D;

  logic [WIDTH-1:0] count  [NCH];
  logic [WIDTH-1:0] period [NCH];
  logic [WIDTH-1:0] shadow [NCH];
  logic [WIDTH-1:0] cmp    [NCH];
  logic [3:0]       ctrl   [NCH];

  logic [NCH-1:0]   status;
  logic [NCH-1:0]   term;
  logic [NCH-1:0]   st_clr;
  logic [NCH-1:0]   pwm_en;
  logic [NCH-1:0]   irq_en;
  logic [NCH-1:0]   pwm_nx;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic [31:0]      wmask;
  logic [31:0]      rdata;
  logic [5:0]       word;
  logic             req;
  logic             wr;
  logic             rd;
  logic             tick;
  logic             wr_pre;
  logic             unused_adr;

  function automatic logic [WIDTH-1:0] merge_w(input logic [WIDTH-1:0] old,
                                               input logic [WIDTH-1:0] nw,
                                               input logic [WIDTH-1:0] m);
    return (old & ~m) | (nw & m);
  endfunction

  function automatic logic [PRE_W-1:0] merge_p(input logic [PRE_W-1:0] old,
                                               input logic [PRE_W-1:0] nw,
                                               input logic [PRE_W-1:0] m);
    return (old & ~m) | (nw & m);
  endfunction

  // The cycle right after an ack never starts a new transfer.
  assign req    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr     = req & wbs_we_i;
  assign rd     = req & ~wbs_we_i;
  assign word   = wbs_adr_i[7:2];
  assign wr_pre = wr & (word == ADR_PRESCALE);
  assign tick   = (pre_cnt == prescale);
  assign wmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                   {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign st_clr = (wr && word == ADR_STATUS) ?
                  (wbs_dat_i[NCH-1:0] & wmask[NCH-1:0]) : '0;
  assign pwm_oeb_o  = ~pwm_en;
  assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

  always_comb begin
    term   = '0;
    pwm_en = '0;
    irq_en = '0;
    pwm_nx = '0;
    for (int c = 0; c < NCH; c++) begin
      term[c]   = ctrl[c][0] & tick & (count[c] == period[c]);
      pwm_en[c] = ctrl[c][2];
      irq_en[c] = ctrl[c][3];
      pwm_nx[c] = ctrl[c][2] & (count[c] < cmp[c]);
    end
  end

  always_comb begin
    rdata = '0;
    if (word == ADR_STATUS) begin
      rdata = 32'(status);
    end else if (word == ADR_PRESCALE) begin
      rdata = 32'(prescale);
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wbs_adr_i[7:4] == 4'(c)) begin
          case (wbs_adr_i[3:2])
            2'd0:    rdata = 32'(ctrl[c]);
            2'd1:    rdata = 32'(shadow[c]);
            2'd2:    rdata = 32'(cmp[c]);
            default: rdata = 32'(count[c]);
          endcase
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      pwm_o     <= '0;
      irq_o     <= 1'b0;
      status    <= '0;
      prescale  <= '0;
      pre_cnt   <= '0;
      for (int c = 0; c < NCH; c++) begin
        count[c]  <= '0;
        period[c] <= '0;
        shadow[c] <= '0;
        cmp[c]    <= '0;
        ctrl[c]   <= '0;
      end
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : '0;
      pwm_o     <= pwm_nx;
      irq_o     <= |(status & irq_en);
      // A terminal tick landing on a W1C of the same bit keeps the flag set.
      status    <= (status & ~st_clr) | term;

      if (wr_pre) begin
        prescale <= merge_p(prescale, wbs_dat_i[PRE_W-1:0], wmask[PRE_W-1:0]);
        pre_cnt  <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end

      for (int c = 0; c < NCH; c++) begin
        if (term[c]) begin
          if (ctrl[c][1]) begin
            ctrl[c][0] <= 1'b0;
          end else begin
            count[c]  <= '0;
            period[c] <= shadow[c];
          end
        end else if (ctrl[c][0] && tick) begin
          count[c] <= count[c] + WIDTH'(1);
        end

        // Register writes are ordered last so they override the counter.
        if (wr && wbs_adr_i[7:4] == 4'(c)) begin
          case (wbs_adr_i[3:2])
            2'd0: begin
              if (wbs_sel_i[0]) begin
                ctrl[c] <= wbs_dat_i[3:0];
                if (wbs_dat_i[0] && !ctrl[c][0]) begin
                  count[c]  <= '0;
                  period[c] <= shadow[c];
                end
              end
            end
            2'd1:    shadow[c] <= merge_w(shadow[c], wbs_dat_i[WIDTH-1:0], wmask[WIDTH-1:0]);
            2'd2:    cmp[c]    <= merge_w(cmp[c], wbs_dat_i[WIDTH-1:0], wmask[WIDTH-1:0]);
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_user_proj_timer_mc.sv
// Directed bench for user_proj_timer_mc: a cycle-level behavioural model is
// compared with the DUT outputs on every falling edge, plus literal checks.
module tb_user_proj_timer_mc;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]     sel = 4'h0;
  logic [31:0]    adr = '0, dat = '0;
  logic           ack, irq;
  logic [31:0]    dat_o;
  logic [NCH-1:0] pwm, oeb;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [31:0]    m_cnt [NCH];
  logic [31:0]    m_per [NCH];
  logic [31:0]    m_shd [NCH];
  logic [31:0]    m_cmp [NCH];
  logic [3:0]     m_ctrl[NCH];
  logic [NCH-1:0] m_stat, m_pwm;
  logic [31:0]    m_pres, m_pre, m_dat;
  logic           m_ack, m_irq;

  user_proj_timer_mc #(.NCH(NCH), .WIDTH(32), .PRE_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .pwm_o    (pwm),
    .pwm_oeb_o(oeb),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int c;
    if (a == 8'hF0) return 32'(m_stat);
    if (a == 8'hF4) return m_pres;
    if (a < 8'(16*NCH)) begin
      c = int'(a[7:4]);
      case (a[3:0])
        4'h0:    return {28'h0, m_ctrl[c]};
        4'h4:    return m_shd[c];
        4'h8:    return m_cmp[c];
        default: return m_cnt[c];
      endcase
    end
    return 32'h0;
  endfunction

  function automatic logic [NCH-1:0] model_oeb();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = ~m_ctrl[i][2];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_per[i] = 0; m_shd[i] = 0; m_cmp[i] = 0; m_ctrl[i] = 0;
    end
    m_stat = '0; m_pwm = '0; m_pres = 0; m_pre = 0; m_dat = 0; m_ack = 0; m_irq = 0;
  endtask

  // One clock edge of the timer, computed from the values held before the edge.
  task automatic model_edge();
    logic [31:0] rd, mw, msk;
    logic [7:0] a;
    logic req, tick, irq_n;
    logic [NCH-1:0] fire, clr, pwm_n;
    logic [3:0] was[NCH];
    int c;
    req   = stb && cyc && !m_ack;
    a     = adr[7:0] & 8'hFC;
    tick  = (m_pre == m_pres);
    rd    = model_read(a);
    irq_n = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      was[i]   = m_ctrl[i];
      fire[i]  = m_ctrl[i][0] && tick && (m_cnt[i] == m_per[i]);
      pwm_n[i] = m_ctrl[i][2] && (m_cnt[i] < m_cmp[i]);
      if (m_stat[i] && m_ctrl[i][3]) irq_n = 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (fire[i]) begin
        if (m_ctrl[i][1]) m_ctrl[i][0] = 1'b0;
        else begin m_cnt[i] = 0; m_per[i] = m_shd[i]; end
      end else if (m_ctrl[i][0] && tick) begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_pre = tick ? 0 : m_pre + 1;
    clr = '0;
    if (req && we) begin
      msk = bmerge(32'h0, 32'hFFFF_FFFF, sel);
      if (a == 8'hF0) clr = dat[NCH-1:0] & msk[NCH-1:0];
      else if (a == 8'hF4) begin
        m_pres = bmerge(m_pres, dat, sel) & 32'h0000_FFFF;
        m_pre  = 0;
      end else if (a < 8'(16*NCH)) begin
        c = int'(a[7:4]);
        case (a[3:0])
          4'h0: if (sel[0]) begin
            mw = dat;
            if (mw[0] && !was[c][0]) begin m_cnt[c] = 0; m_per[c] = m_shd[c]; end
            m_ctrl[c] = mw[3:0];
          end
          4'h4:    m_shd[c] = bmerge(m_shd[c], dat, sel);
          4'h8:    m_cmp[c] = bmerge(m_cmp[c], dat, sel);
          default: ;
        endcase
      end
    end
    m_stat = (m_stat & ~clr) | fire;
    m_ack  = req;
    m_dat  = (req && !we) ? rd : 32'h0;
    m_pwm  = pwm_n;
    m_irq  = irq_n;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("ack", 32'(ack), 32'(m_ack));
      chk("dat_o", dat_o, m_dat);
      chk("pwm_o", 32'(pwm), 32'(m_pwm));
      chk("pwm_oeb_o", 32'(oeb), 32'(model_oeb()));
      chk("irq_o", 32'(irq), 32'(m_irq));
    end
  end

  task automatic wb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] q);
    int n;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = {24'h0, a}; dat = d; sel = s;
    n = 0;
    do begin @(negedge clk); n++; end while (ack !== 1'b1 && n < 10);
    if (ack !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL ack_timeout: got 0 expected 1 at addr 0x%0h", a);
    end
    q = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, s, q);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp,
                        input logic [31:0] mask = 32'hFFFF_FFFF);
    logic [31:0] q;
    wb_xfer(1'b0, a, 32'h0, 4'hF, q);
    chk(name, q & mask, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_high(input int ch, input int n, output int h);
    h = 0;
    repeat (n) begin @(negedge clk); if (pwm[ch] === 1'b1) h++; end
  endtask

  task automatic pwm0_gap(output int g);
    g = 0;
    do begin @(negedge clk); g++; end while (pwm[0] !== 1'b1 && g < 50);
  endtask

  initial begin
    int h, g;
    #1 rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;

    // Reset state
    chk("rst_pwm", 32'(pwm), 32'h0);
    chk("rst_oeb", 32'(oeb), 32'hF);
    chk("rst_irq", 32'(irq), 32'h0);
    rd_chk("rst_ctrl0", 8'h00, 32'h0);
    rd_chk("rst_status", 8'hF0, 32'h0);

    // Periodic channel 0 with interrupt
    wb_write(8'hF4, 32'h0);
    wb_write(8'h04, 32'd4);
    wb_write(8'h00, 32'h9);
    wait_cyc(20);
    chk("per_irq_high", 32'(irq), 32'h1);
    wb_write(8'h00, 32'h8);
    rd_chk("per_status", 8'hF0, 32'h1);
    wb_write(8'hF0, 32'h1);
    wait_cyc(3);
    chk("per_irq_low", 32'(irq), 32'h0);
    rd_chk("per_status_clr", 8'hF0, 32'h0);

    // One-shot channel 1 with prescaler
    wb_write(8'hF4, 32'd2);
    wb_write(8'h14, 32'd3);
    wb_write(8'h10, 32'h3);
    wait_cyc(40);
    rd_chk("os_ctrl", 8'h10, 32'h2);
    rd_chk("os_count", 8'h1C, 32'd3);
    rd_chk("os_status", 8'hF0, 32'h2);
    wait_cyc(10);
    rd_chk("os_count_frozen", 8'h1C, 32'd3);
    wb_write(8'hF0, 32'h2);

    // PWM on channel 2
    wb_write(8'hF4, 32'h0);
    wb_write(8'h24, 32'd9);
    wb_write(8'h28, 32'd3);
    wb_write(8'h20, 32'h5);
    wait_cyc(20);
    chk("pwm_oeb2", 32'(oeb), 32'hB);
    count_high(2, 100, h);
    chk("pwm_duty_3of10", h, 32'd30);
    wb_write(8'h28, 32'd0);
    wait_cyc(3);
    count_high(2, 20, h);
    chk("pwm_cmp0_low", h, 32'd0);
    wb_write(8'h28, 32'd20);
    wait_cyc(3);
    count_high(2, 20, h);
    chk("pwm_cmp_big_high", h, 32'd20);
    wb_write(8'h20, 32'h0);

    // Shadowed LOAD: period 10 completes, then 3-cycle periods
    wb_write(8'h04, 32'd9);
    wb_write(8'h08, 32'd1);
    wb_write(8'h00, 32'h5);
    fork
      begin wait_cyc(4); wb_write(8'h04, 32'd2); end
      begin
        pwm0_gap(g);
        pwm0_gap(g); chk("shadow_first_period", g, 32'd10);
        pwm0_gap(g); chk("shadow_next_period", g, 32'd3);
        pwm0_gap(g); chk("shadow_next_period2", g, 32'd3);
      end
    join
    chk("shadow_oeb", 32'(oeb), 32'hE);

    // Period 0: flag sets every tick, W1C loses against the set
    wb_write(8'h34, 32'd0);
    wb_write(8'h30, 32'h9);
    wait_cyc(5);
    chk("p0_irq", 32'(irq), 32'h1);
    wb_write(8'hF0, 32'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w1c_set_wins_irq", 32'(irq), 32'h1);
    end
    rd_chk("p0_count", 8'h3C, 32'h0);
    rd_chk("p0_status", 8'hF0, 32'h8, 32'h8);
    wb_write(8'h30, 32'h0);
    wb_write(8'hF0, 32'hF);

    // Bus edge cases
    rd_chk("unmapped_e0", 8'hE0, 32'h0);
    @(negedge clk);
    chk("single_ack", 32'(ack), 32'h0);
    rd_chk("chan4_absent", 8'h44, 32'h0);
    wb_write(8'h14, 32'h1122_3344);
    wb_write(8'h14, 32'hAABB_CCDD, 4'b0001);
    rd_chk("byte_sel_load", 8'h14, 32'h1122_33DD);
    wb_write(8'h1C, 32'hFF);
    rd_chk("count_ro", 8'h1C, 32'd3);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h1C;
    chk("hold_ack0", 32'(ack), 32'h0);
    @(negedge clk); chk("hold_ack1", 32'(ack), 32'h1);
    @(negedge clk); chk("hold_ack2", 32'(ack), 32'h0);
    @(negedge clk); chk("hold_ack3", 32'(ack), 32'h1);
    stb = 1'b0; cyc = 1'b0;

    // Asynchronous reset in the middle of an ack
    wb_write(8'h20, 32'h5);
    wb_write(8'h30, 32'h9);
    wait_cyc(6);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h04;
    @(posedge clk);
    #2;
    chk("inflight_ack", 32'(ack), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack), 32'h0);
    chk("arst_dat", dat_o, 32'h0);
    chk("arst_pwm", 32'(pwm), 32'h0);
    chk("arst_oeb", 32'(oeb), 32'hF);
    chk("arst_irq", 32'(irq), 32'h0);
    stb = 1'b0; cyc = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    rd_chk("arst_ctrl0", 8'h00, 32'h0);
    rd_chk("arst_load0", 8'h04, 32'h0);
    rd_chk("arst_count0", 8'h0C, 32'h0);
    rd_chk("arst_load1", 8'h14, 32'h0);
    rd_chk("arst_status", 8'hF0, 32'h0);
    rd_chk("arst_prescale", 8'hF4, 32'h0);
    wait_cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
